md_unit: RTL

- Multi-cycle multiply/divide unit with HI/LO registers for the EX stage. It sits beside the combinational ALU.
- It executes MULT/MULTU/DIV/DIVU over a fixed, parameterised latency and performs MTHI/MTLO writes.
- It exposes HI/LO for MFHI/MFLO and a Busy flag, which hazard control ORs with an MD request in EX to stall the pipeline.
- Operand width and each latency are parameters.

---
 rtl/md_unit_if.sv | 17 +
 rtl/md_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The master drives the operands, the op select and the strobe. The slave
// returns Busy and the HI/LO registers.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       MDOp;
  logic             En;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output A, B, MDOp, En, input Busy, HI, LO);
  modport slave  (input A, B, MDOp, En, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// A request taken in IDLE latches its operands. The unit then stays in RUN for a
// fixed number of cycles, and on the last RUN edge it commits the result,
// which is computed from the latched operands. MTHI/MTLO write in a single cycle.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath runs off the latched operands only, so a change on A/B during RUN has no effect
  logic [2*WIDTH-1:0]        prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      div_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          divisor;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          quot_u;
  logic [WIDTH-1:0]          rem_u;

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Dividing by 1 stands in for the two awkward cases. With a zero divisor
  // the result is thrown away. On signed overflow (most-negative / -1) a
  // divide by 1 already gives the required quotient (A) and remainder (0).
  assign div_zero = (b_q == '0);
  assign div_ovf  = (op_q == OP_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  assign divisor  = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;

  assign quot_s = $signed(a_q) / $signed(divisor);
  assign rem_s  = $signed(a_q) % $signed(divisor);
  assign quot_u = a_q / divisor;
  assign rem_u  = a_q % divisor;

  // State and register update; reset takes priority and aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: accept requests only in IDLE, commit the result on the last RUN edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.En) begin
          case (bus.MDOp)
            OP_MULT, OP_MULTU: begin
              a_d     = bus.A;
              b_d     = bus.B;
              op_d    = bus.MDOp;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = bus.A;
              b_d     = bus.B;
              op_d    = bus.MDOp;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (!div_zero) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
